video_timing_gen_p: RTL and testbench

//   Parametrised raster timing generator, successor to the fixed 384x264 generator.
//   - Produces H/V counters, raw and flipped position buses, blanking, syncs, frame parity and the sprite DMA window.
//   - Adds line/frame strobes and a programmable raster-line interrupt with acknowledge.
//   - Sits at the head of the video pipeline and feeds the tilemap, sprite and CRTC blocks.

---
 rtl/video_timing_gen_p.sv | 139 +++++++++++++
 tb/tb_video_timing_gen_p.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen_p.sv
// video_timing_gen_p
//   Parametrised raster timing generator. Produces the H/V counters, raw and
//   flipped position buses, blanking, syncs, frame parity and the sprite DMA
//   window. It also produces line and frame strobes and a programmable
//   raster-line interrupt that is cleared by an acknowledge pulse.
//
// Ports
//   i_EMU_MCLK        master clock
//   i_MRST            synchronous active-high reset
//   i_EMU_CLK6MPCEN_n pixel-clock enable, active low; qualifies every state change
//   i_HFLIP, i_VFLIP  invert the flipped position buses
//   i_IRQ_EN          raster interrupt enable (blocks new sets only)
//   i_IRQ_LINE        V count that raises the interrupt
//   i_IRQ_ACK         single-MCLK pulse that clears o_IRQ_n
//   o_ABS_H, o_ABS_V  raw counters
//   o_FLIP_H, o_FLIP_V low counter bits XOR flip (combinational)
//   o_HBLANK_n, o_VBLANK_n, o_HSYNC_n, o_VSYNC_n, o_CSYNC_n, o_DMA_n  window flags
//   o_FRAMEPARITY     toggles on entry to PAR_LINE
//   o_LINE_STB        one-MCLK pulse on each V advance
//   o_FRAME_STB       one-MCLK pulse when V wraps to V_START
//   o_IRQ_n           raster interrupt, active low, level-held
module video_timing_gen_p #(
  parameter int HW          = 9,
  parameter int VW          = 9,
  parameter int H_START     = 128,
  parameter int H_END       = 511,
  parameter int H_VINC      = 175,
  parameter int H_ACT       = 256,
  parameter int HS_START    = 175,
  parameter int HS_END      = 206,
  parameter int V_START     = 248,
  parameter int V_END       = 511,
  parameter int V_ACT_FIRST = 272,
  parameter int V_ACT_LAST  = 496,
  parameter int VS_FIRST    = 248,
  parameter int VS_LAST     = 255,
  parameter int DMA_FIRST   = 480,
  parameter int DMA_LAST    = 496,
  parameter int PAR_LINE    = 496
) (
  input  logic          i_EMU_MCLK,
  input  logic          i_MRST,
  input  logic          i_EMU_CLK6MPCEN_n,
  input  logic          i_HFLIP,
  input  logic          i_VFLIP,
  input  logic          i_IRQ_EN,
  input  logic [VW-1:0] i_IRQ_LINE,
  input  logic          i_IRQ_ACK,
  output logic [HW-1:0] o_ABS_H,
  output logic [VW-1:0] o_ABS_V,
  output logic [HW-2:0] o_FLIP_H,
  output logic [VW-2:0] o_FLIP_V,
  output logic          o_HBLANK_n,
  output logic          o_VBLANK_n,
  output logic          o_HSYNC_n,
  output logic          o_VSYNC_n,
  output logic          o_CSYNC_n,
  output logic          o_DMA_n,
  output logic          o_FRAMEPARITY,
  output logic          o_LINE_STB,
  output logic          o_FRAME_STB,
  output logic          o_IRQ_n
);

  localparam logic [HW-1:0] H_START_C  = HW'(H_START);
  localparam logic [HW-1:0] H_END_C    = HW'(H_END);
  localparam logic [HW-1:0] H_VINC_C   = HW'(H_VINC);
  localparam logic [HW-1:0] H_ACT_C    = HW'(H_ACT);
  localparam logic [HW-1:0] HS_START_C = HW'(HS_START);
  localparam logic [HW-1:0] HS_END_C   = HW'(HS_END);
  localparam logic [VW-1:0] V_START_C  = VW'(V_START);
  localparam logic [VW-1:0] V_END_C    = VW'(V_END);
  localparam logic [VW-1:0] V_ACTF_C   = VW'(V_ACT_FIRST);
  localparam logic [VW-1:0] V_ACTL_C   = VW'(V_ACT_LAST);
  localparam logic [VW-1:0] VS_FIRST_C = VW'(VS_FIRST);
  localparam logic [VW-1:0] VS_LAST_C  = VW'(VS_LAST);
  localparam logic [VW-1:0] DMA_F_C    = VW'(DMA_FIRST);
  localparam logic [VW-1:0] DMA_L_C    = VW'(DMA_LAST);
  localparam logic [VW-1:0] PAR_C      = VW'(PAR_LINE);

  logic          tick;
  logic          v_adv;
  logic [HW-1:0] h_wrap;
  logic [VW-1:0] v_wrap;
  logic [HW-1:0] h_load;
  logic [VW-1:0] v_load;

  // h_load/v_load are the values the counters take on this edge, reset
  // included, so the window flags derived from them line up with the counters
  // and also take their reset values from the same comparisons.
  always_comb begin
    tick   = ~i_EMU_CLK6MPCEN_n;
    h_wrap = (o_ABS_H == H_END_C) ? H_START_C : o_ABS_H + 1'b1;
    v_wrap = (o_ABS_V == V_END_C) ? V_START_C : o_ABS_V + 1'b1;
    v_adv  = tick && (o_ABS_H == H_VINC_C);
    h_load = o_ABS_H;
    v_load = o_ABS_V;
    if (i_MRST) begin
      h_load = H_START_C;
      v_load = V_START_C;
    end else begin
      if (tick)  h_load = h_wrap;
      if (v_adv) v_load = v_wrap;
    end
  end

  always_ff @(posedge i_EMU_MCLK) begin
    o_ABS_H    <= h_load;
    o_ABS_V    <= v_load;
    o_HBLANK_n <= (h_load >= H_ACT_C);
    o_HSYNC_n  <= ~((h_load >= HS_START_C) && (h_load <= HS_END_C));
    o_VBLANK_n <= (v_load >= V_ACTF_C) && (v_load <= V_ACTL_C);
    o_VSYNC_n  <= ~((v_load >= VS_FIRST_C) && (v_load <= VS_LAST_C));
    o_DMA_n    <= ~((v_load >= DMA_F_C) && (v_load <= DMA_L_C));
    if (i_MRST) begin
      o_FRAMEPARITY <= 1'b0;
      o_LINE_STB    <= 1'b0;
      o_FRAME_STB   <= 1'b0;
      o_IRQ_n       <= 1'b1;
    end else begin
      o_LINE_STB  <= v_adv;
      o_FRAME_STB <= v_adv && (o_ABS_V == V_END_C);
      if (v_adv && (v_wrap == PAR_C))
        o_FRAMEPARITY <= ~o_FRAMEPARITY;
      // A set on the same edge as an acknowledge wins.
      if (v_adv && i_IRQ_EN && (v_wrap == i_IRQ_LINE))
        o_IRQ_n <= 1'b0;
      else if (i_IRQ_ACK)
        o_IRQ_n <= 1'b1;
    end
  end

  always_comb begin
    o_FLIP_H  = o_ABS_H[HW-2:0] ^ {(HW-1){i_HFLIP}};
    o_FLIP_V  = o_ABS_V[VW-2:0] ^ {(VW-1){i_VFLIP}};
    o_CSYNC_n = o_HSYNC_n & o_VSYNC_n;
  end

endmodule

// File: tb/tb_video_timing_gen_p.sv
module tb_video_timing_gen_p;

  // Horizontal timing at the defaults; vertical span shortened so several
  // frames fit in the cycle budget while still covering lines 260 and 300.
  localparam int HW = 9, VW = 9;
  localparam int H_START = 128, H_END = 511, H_VINC = 175, H_ACT = 256;
  localparam int HS_START = 175, HS_END = 206;
  localparam int V_START = 248, V_END = 303;
  localparam int V_ACT_FIRST = 260, V_ACT_LAST = 295;
  localparam int VS_FIRST = 248, VS_LAST = 251;
  localparam int DMA_FIRST = 285, DMA_LAST = 295, PAR_LINE = 295;

  localparam int HL = H_END - H_START + 1;
  localparam int VL = V_END - V_START + 1;
  localparam int D1 = H_VINC - H_START + 1;   // ticks from reset to first V advance
  localparam int NCYC = 60000;

  logic clk = 1'b0;
  logic rst, en_n, hflip, vflip, irq_en, irq_ack;
  logic [VW-1:0] irq_line;
  logic [HW-1:0] abs_h;
  logic [VW-1:0] abs_v;
  logic [HW-2:0] flip_h;
  logic [VW-2:0] flip_v;
  logic hblank_n, vblank_n, hsync_n, vsync_n, csync_n, dma_n, parity;
  logic line_stb, frame_stb, irq_n;

  always #5 clk = ~clk;

  video_timing_gen_p #(
    .HW(HW), .VW(VW), .H_START(H_START), .H_END(H_END), .H_VINC(H_VINC),
    .H_ACT(H_ACT), .HS_START(HS_START), .HS_END(HS_END),
    .V_START(V_START), .V_END(V_END), .V_ACT_FIRST(V_ACT_FIRST),
    .V_ACT_LAST(V_ACT_LAST), .VS_FIRST(VS_FIRST), .VS_LAST(VS_LAST),
    .DMA_FIRST(DMA_FIRST), .DMA_LAST(DMA_LAST), .PAR_LINE(PAR_LINE)
  ) dut (
    .i_EMU_MCLK(clk), .i_MRST(rst), .i_EMU_CLK6MPCEN_n(en_n),
    .i_HFLIP(hflip), .i_VFLIP(vflip), .i_IRQ_EN(irq_en),
    .i_IRQ_LINE(irq_line), .i_IRQ_ACK(irq_ack),
    .o_ABS_H(abs_h), .o_ABS_V(abs_v), .o_FLIP_H(flip_h), .o_FLIP_V(flip_v),
    .o_HBLANK_n(hblank_n), .o_VBLANK_n(vblank_n), .o_HSYNC_n(hsync_n),
    .o_VSYNC_n(vsync_n), .o_CSYNC_n(csync_n), .o_DMA_n(dma_n),
    .o_FRAMEPARITY(parity), .o_LINE_STB(line_stb), .o_FRAME_STB(frame_stb),
    .o_IRQ_n(irq_n)
  );

  typedef struct packed {
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [HW-2:0] fh;
    logic [VW-2:0] fv;
    logic hb, vb, hs, vs, cs, dma, par, ls, fs, irq;
  } obs_t;

  obs_t exp_q[$];
  int total = 0;
  int bad = 0;

  // Reference model state: ticks since reset and the pending interrupt.
  int  p;
  bit  irq_pend, ls_m, fs_m;

  function automatic int line_of(input int ticks);
    return (ticks + HL - D1) / HL;
  endfunction

  function automatic int vpos(input int ticks);
    return V_START + (line_of(ticks) % VL);
  endfunction

  function automatic obs_t expected();
    obs_t e;
    int h, v, l, k;
    h = H_START + (p % HL);
    l = line_of(p);
    v = V_START + (l % VL);
    k = PAR_LINE - V_START;
    e.h   = HW'(h);
    e.v   = VW'(v);
    e.fh  = e.h[HW-2:0] ^ {(HW-1){hflip}};
    e.fv  = e.v[VW-2:0] ^ {(VW-1){vflip}};
    e.hb  = (h >= H_ACT);
    e.hs  = !(h >= HS_START && h <= HS_END);
    e.vb  = (v >= V_ACT_FIRST && v <= V_ACT_LAST);
    e.vs  = !(v >= VS_FIRST && v <= VS_LAST);
    e.cs  = e.hs && e.vs;
    e.dma = !(v >= DMA_FIRST && v <= DMA_LAST);
    // Parity = number of entries into PAR_LINE since reset, mod 2.
    e.par = 1'(((l + VL - k) / VL - (k == 0 ? 1 : 0)) % 2);
    e.ls  = ls_m;
    e.fs  = fs_m;
    e.irq = !irq_pend;
    return e;
  endfunction

  // Applies the inputs currently driven to the model for one MCLK edge.
  task automatic model_step();
    bit set;
    set = 0;
    ls_m = 0;
    fs_m = 0;
    if (rst) begin
      p = 0;
      irq_pend = 0;
    end else begin
      if (!en_n) begin
        int lo;
        lo = line_of(p);
        p++;
        if (line_of(p) != lo) begin
          ls_m = 1;
          if (line_of(p) % VL == 0) fs_m = 1;
          if (irq_en && vpos(p) == int'(irq_line)) set = 1;
        end
      end
      if (set) irq_pend = 1;
      else if (irq_ack) irq_pend = 0;
    end
  endtask

  // Driver: inputs change 2 time units after each rising edge; the expected
  // observation after the next edge is queued immediately.
  initial begin
    int wait_cyc;
    rst = 1; en_n = 1; hflip = 0; vflip = 0; irq_en = 1; irq_ack = 0;
    irq_line = VW'(300);
    p = 0; irq_pend = 0;
    model_step();
    exp_q.push_back(expected());
    for (int c = 1; c < NCYC; c++) begin
      bit would_set;
      @(posedge clk);
      #2;
      rst   = (c == 1) || (c == 52000);
      en_n  = ($urandom_range(15) == 0) || (c >= 20000 && c < 20050);
      hflip = 1'($urandom_range(1));
      vflip = 1'($urandom_range(1));
      if (c % 3000 == 0) begin
        irq_en   = ($urandom_range(3) != 0);
        irq_line = VW'($urandom_range(V_END, V_START));
      end
      would_set = !rst && !en_n && irq_en &&
                  (line_of(p + 1) != line_of(p)) && (vpos(p + 1) == int'(irq_line));
      irq_ack = would_set ? 1'($urandom_range(1)) : ($urandom_range(63) == 0);
      model_step();
      exp_q.push_back(expected());
    end
    @(posedge clk);
    #2;
    rst = 0; en_n = 1; irq_ack = 0;
    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #3;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Monitor: one observation per edge, sampled 1 time unit after it.
  always begin
    obs_t e, a;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = '{abs_h, abs_v, flip_h, flip_v, hblank_n, vblank_n, hsync_n, vsync_n,
            csync_n, dma_n, parity, line_stb, frame_stb, irq_n};
      total++;
      if (a !== e) begin
        bad++;
        if (bad <= 20)
          $display("FAIL outputs @%0t: actual h=%0d v=%0d fh=%h fv=%h hb%b vb%b hs%b vs%b cs%b dma%b par%b ls%b fs%b irq%b required h=%0d v=%0d fh=%h fv=%h hb%b vb%b hs%b vs%b cs%b dma%b par%b ls%b fs%b irq%b",
                   $time, a.h, a.v, a.fh, a.fv, a.hb, a.vb, a.hs, a.vs, a.cs, a.dma, a.par, a.ls, a.fs, a.irq,
                   e.h, e.v, e.fh, e.fv, e.hb, e.vb, e.hs, e.vs, e.cs, e.dma, e.par, e.ls, e.fs, e.irq);
      end
    end
  end

endmodule
